// File: rtl/reversi_pkg.sv
// -----------------------------------------------------------------------------
// reversi_pkg
// Shared definitions for the Reversi board register:
//   - 3-bit cell encodings (EMPTY / ENABLE / BLACK / WHITE)
//   - command opcodes carried on cmd_op
//   - clog2 helper used to size index and count buses
//   - cell_norm: folds every unrecognised cell code onto EMPTY
// -----------------------------------------------------------------------------
package reversi_pkg;

    localparam logic [2:0] CELL_EMPTY  = 3'b000;
    localparam logic [2:0] CELL_ENABLE = 3'b100;
    localparam logic [2:0] CELL_BLACK  = 3'b111;
    localparam logic [2:0] CELL_WHITE  = 3'b110;

    typedef enum logic [2:0] {
        OP_NOP         = 3'd0,
        OP_INIT        = 3'd1,
        OP_MARK        = 3'd2,
        OP_PLACE       = 3'd3,
        OP_FLIP        = 3'd4,
        OP_CLEAR_MARKS = 3'd5
    } cmd_op_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic logic [2:0] cell_norm(input logic [2:0] s);
        case (s)
            CELL_ENABLE, CELL_BLACK, CELL_WHITE: return s;
            default:                             return CELL_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/reversi_cell_next.sv
// -----------------------------------------------------------------------------
// reversi_cell_next
// Combinational next-state function for a single board cell. The top level
// instantiates one per cell and commits the result only on a command accept.
//
// Ports:
//   i_cur         current 3-bit cell code
//   i_op          command opcode
//   i_mask        this cell's bit of the MARK / FLIP select mask
//   i_place_hit   this cell is the target of an accepted, legal PLACE
//   i_black       PLACE colour (1 black, 0 white)
//   i_init_value  this cell's code after INIT (centre stones or EMPTY)
//   o_next        next 3-bit cell code
// -----------------------------------------------------------------------------
module reversi_cell_next
    import reversi_pkg::*;
(
    input  logic [2:0] i_cur,
    input  logic [2:0] i_op,
    input  logic       i_mask,
    input  logic       i_place_hit,
    input  logic       i_black,
    input  logic [2:0] i_init_value,
    output logic [2:0] o_next
);

    logic [2:0] w_cur;

    assign w_cur = cell_norm(i_cur);

    always_comb begin
        o_next = w_cur;
        case (i_op)
            OP_INIT: begin
                o_next = i_init_value;
            end
            OP_MARK: begin
                if (i_mask && (w_cur == CELL_EMPTY)) o_next = CELL_ENABLE;
            end
            OP_CLEAR_MARKS: begin
                if (w_cur == CELL_ENABLE) o_next = CELL_EMPTY;
            end
            OP_PLACE: begin
                if (i_place_hit) o_next = i_black ? CELL_BLACK : CELL_WHITE;
            end
            OP_FLIP: begin
                if (i_mask) begin
                    if (w_cur == CELL_BLACK)      o_next = CELL_WHITE;
                    else if (w_cur == CELL_WHITE) o_next = CELL_BLACK;
                end
            end
            default: begin
                o_next = w_cur;
            end
        endcase
    end

endmodule

// File: rtl/reversi_board_reg.sv
// -----------------------------------------------------------------------------
// reversi_board_reg
// Registered SIZE x SIZE Reversi board. Whole-board commands arrive over a
// valid/ready handshake and update every cell on the accept edge. Every
// board-modifying command is followed by a one-cell-per-cycle scan that
// recounts black and white stones; the FSM is busy for exactly CELLS cycles.
// SIZE must be even and at least 4.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only while IDLE)
//   cmd_op               0 NOP, 1 INIT, 2 MARK, 3 PLACE, 4 FLIP, 5 CLEAR_MARKS
//   cmd_idx, cmd_black   PLACE target (row*SIZE+col) and colour
//   cmd_mask             per-cell select for MARK and FLIP
//   rd_idx, rd_state     combinational cell read (EMPTY when out of range)
//   black_cnt/white_cnt  stone counts, valid while cnt_valid=1
//   done                 one-cycle pulse when a recount finishes
//   err                  one-cycle pulse after a rejected PLACE
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a command, counts match the board
// COUNT  | scanning cell r_ptr, accumulating stones, commands held off
// -----------------------------------------------------------------------------
module reversi_board_reg
    import reversi_pkg::*;
#(
    parameter  int SIZE  = 8,
    localparam int CELLS = SIZE * SIZE,
    localparam int IDX_W = clog2(CELLS),
    localparam int CNT_W = clog2(CELLS + 1)
)(
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [IDX_W-1:0] cmd_idx,
    input  logic             cmd_black,
    input  logic [CELLS-1:0] cmd_mask,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [2:0]       rd_state,
    output logic [CNT_W-1:0] black_cnt,
    output logic [CNT_W-1:0] white_cnt,
    output logic             cnt_valid,
    output logic             done,
    output logic             err
);

    localparam int CTR = SIZE / 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_e;

    state_e           r_state;
    logic [2:0]       r_cells [CELLS];
    logic [IDX_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_acc_black;
    logic [CNT_W-1:0] r_acc_white;
    logic [CNT_W-1:0] r_black_cnt;
    logic [CNT_W-1:0] r_white_cnt;
    logic             r_cnt_valid;
    logic             r_done;
    logic             r_err;

    logic [2:0]       w_next [CELLS];
    logic             w_accept;
    logic             w_idx_in;
    logic             w_rd_in;
    logic [2:0]       w_target;
    logic             w_place_ok;
    logic             w_modify;
    logic [2:0]       w_scan;
    logic [CNT_W-1:0] w_black_sum;
    logic [CNT_W-1:0] w_white_sum;

    assign cmd_ready = (r_state == ST_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;

    // Index buses are wider than CELLS whenever SIZE*SIZE is not a power of
    // two, so both the PLACE target and the read port are range-checked.
    assign w_idx_in   = (32'(cmd_idx) < 32'(CELLS));
    assign w_rd_in    = (32'(rd_idx) < 32'(CELLS));
    assign w_target   = w_idx_in ? cell_norm(r_cells[cmd_idx]) : CELL_EMPTY;
    assign w_place_ok = (cmd_op == OP_PLACE) && w_idx_in && (w_target == CELL_ENABLE);
    assign rd_state   = w_rd_in ? cell_norm(r_cells[rd_idx]) : CELL_EMPTY;

    always_comb begin
        w_modify = 1'b0;
        case (cmd_op)
            OP_INIT, OP_MARK, OP_FLIP, OP_CLEAR_MARKS: w_modify = 1'b1;
            OP_PLACE:                                  w_modify = w_place_ok;
            default:                                   w_modify = 1'b0;
        endcase
    end

    for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
        localparam int ROW = gi / SIZE;
        localparam int COL = gi % SIZE;
        localparam logic [2:0] INIT_V =
            (((ROW == CTR-1) && (COL == CTR-1)) || ((ROW == CTR) && (COL == CTR))) ? CELL_WHITE :
            (((ROW == CTR-1) && (COL == CTR))   || ((ROW == CTR) && (COL == CTR-1))) ? CELL_BLACK :
            CELL_EMPTY;

        logic w_hit;
        assign w_hit = w_place_ok && (cmd_idx == IDX_W'(gi));

        reversi_cell_next u_cell_next (
            .i_cur        (r_cells[gi]),
            .i_op         (cmd_op),
            .i_mask       (cmd_mask[gi]),
            .i_place_hit  (w_hit),
            .i_black      (cmd_black),
            .i_init_value (INIT_V),
            .o_next       (w_next[gi])
        );
    end

    // Scan adders hold at CELLS; with one cell per cycle they can never get
    // there, so the clamp only guards against a corrupted accumulator.
    assign w_scan      = cell_norm(r_cells[r_ptr]);
    assign w_black_sum = ((w_scan == CELL_BLACK) && (r_acc_black != CNT_W'(CELLS)))
                       ? r_acc_black + CNT_W'(1) : r_acc_black;
    assign w_white_sum = ((w_scan == CELL_WHITE) && (r_acc_white != CNT_W'(CELLS)))
                       ? r_acc_white + CNT_W'(1) : r_acc_white;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            for (int i = 0; i < CELLS; i++) r_cells[i] <= CELL_EMPTY;
            r_ptr       <= '0;
            r_acc_black <= '0;
            r_acc_white <= '0;
            r_black_cnt <= '0;
            r_white_cnt <= '0;
            r_cnt_valid <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;

            // Rejected PLACE and NOP produce w_next == current, so committing
            // on every accept is safe.
            if (w_accept) begin
                for (int i = 0; i < CELLS; i++) r_cells[i] <= w_next[i];
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_modify) begin
                            r_state     <= ST_COUNT;
                            r_ptr       <= '0;
                            r_acc_black <= '0;
                            r_acc_white <= '0;
                            r_cnt_valid <= 1'b0;
                        end else if (cmd_op == OP_PLACE) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_COUNT: begin
                    r_acc_black <= w_black_sum;
                    r_acc_white <= w_white_sum;
                    if (r_ptr == IDX_W'(CELLS - 1)) begin
                        r_black_cnt <= w_black_sum;
                        r_white_cnt <= w_white_sum;
                        r_cnt_valid <= 1'b1;
                        r_done      <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_ptr <= r_ptr + IDX_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign black_cnt = r_black_cnt;
    assign white_cnt = r_white_cnt;
    assign cnt_valid = r_cnt_valid;
    assign done      = r_done;
    assign err       = r_err;

endmodule
